// File: rtl/adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : adder_subtractor
// Brief    : Registered WIDTH-bit two's-complement adder/subtractor, 1-cycle
//            latency, with carry, signed overflow and zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module adder_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             mode,
    input  logic             in_valid,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             out_valid
);

    logic [WIDTH-1:0] w_b;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH:0]   w_c;

    // Subtraction is A + ~B + 1: invert B and inject mode as the carry-in.
    assign w_b    = B ^ {WIDTH{mode}};
    assign w_c[0] = mode;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_fa
            assign w_sum[i]  = A[i] ^ w_b[i] ^ w_c[i];
            assign w_c[i+1]  = (A[i] & w_b[i]) | (w_c[i] & (A[i] ^ w_b[i]));
        end
    endgenerate

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic             overflow_q, overflow_d;
    logic             zero_q, zero_d;
    logic             out_valid_q, out_valid_d;

    always_comb begin
        result_d    = result_q;
        carry_d     = carry_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            result_d   = w_sum;
            carry_d    = w_c[WIDTH];
            overflow_d = w_c[WIDTH] ^ w_c[WIDTH-1];
            zero_d     = (w_sum == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_q    <= '0;
            carry_q     <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            carry_q     <= carry_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_adder_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_subtractor
// Brief    : Self-checking bench for adder_subtractor against an arithmetic
//            reference model; directed, exhaustive and random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_subtractor;

    localparam int W   = 4;
    localparam int MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic         mode, in_valid;
    logic [W-1:0] result;
    logic         carry, overflow, zero, out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected outputs held by the reference model
    int e_res, e_c, e_ov, e_z, e_v;

    adder_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .in_valid  (in_valid),
        .result    (result),
        .carry     (carry),
        .overflow  (overflow),
        .zero      (zero),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    // Plain-integer arithmetic model of one operation
    task automatic ref_op(input int a, input int b, input int m,
                          output int res, output int c, output int ov, output int z);
        int s;
        if (m == 0) begin
            res = (a + b) % MOD;
            c   = (a + b >= MOD) ? 1 : 0;
            s   = to_signed(a) + to_signed(b);
        end else begin
            res = (a - b + MOD) % MOD;
            c   = (a >= b) ? 1 : 0;
            s   = to_signed(a) - to_signed(b);
        end
        ov = (s > MOD / 2 - 1 || s < -(MOD / 2)) ? 1 : 0;
        z  = (res == 0) ? 1 : 0;
    endtask

    // Drive one cycle, advance the model, then check all outputs after the edge
    task automatic step(input int a, input int b, input int m, input int v, input int r,
                        input string tag);
        A        = a[W-1:0];
        B        = b[W-1:0];
        mode     = m[0];
        in_valid = v[0];
        rst_n    = r[0];
        @(posedge clk);
        #1;
        if (r == 0) begin
            e_res = 0; e_c = 0; e_ov = 0; e_z = 0; e_v = 0;
        end else begin
            if (v != 0) ref_op(a, b, m, e_res, e_c, e_ov, e_z);
            e_v = v;
        end
        check_eq({tag, ".result"},    int'(result),    e_res);
        check_eq({tag, ".carry"},     int'(carry),     e_c);
        check_eq({tag, ".overflow"},  int'(overflow),  e_ov);
        check_eq({tag, ".zero"},      int'(zero),      e_z);
        check_eq({tag, ".out_valid"}, int'(out_valid), e_v);
        // Wiggle inputs mid-cycle; only edge samples may matter
        A    = W'($urandom);
        B    = W'($urandom);
        mode = 1'($urandom);
    endtask

    initial begin
        e_res = 0; e_c = 0; e_ov = 0; e_z = 0; e_v = 0;
        A = '0; B = '0; mode = 1'b0; in_valid = 1'b0; rst_n = 1'b0;
        #1;

        step(0, 0, 0, 0, 0, "reset0");
        step(0, 0, 0, 1, 0, "reset1");

        step(2, 3, 0, 1, 1, "add_2_3");
        step(7, 6, 0, 1, 1, "add_ovf");
        step(15, 1, 0, 1, 1, "add_wrap_zero");
        step(8, 3, 1, 1, 1, "sub_8_3");
        step(9, 5, 1, 1, 1, "sub_9_5");
        step(3, 5, 1, 1, 1, "sub_borrow");
        step(8, 1, 1, 1, 1, "sub_ovf");
        step(12, 4, 0, 0, 1, "hold1");
        step(1, 9, 1, 0, 1, "hold2");
        step(6, 6, 1, 1, 1, "sub_zero");
        step(7, 6, 0, 1, 0, "reset_midop");
        step(4, 4, 0, 1, 1, "post_reset");

        for (int a = 0; a < MOD; a++)
            for (int b = 0; b < MOD; b++)
                for (int m = 0; m < 2; m++)
                    step(a, b, m, 1, 1, "sweep");

        for (int i = 0; i < 300; i++)
            step(int'($urandom_range(MOD - 1)), int'($urandom_range(MOD - 1)),
                 int'($urandom_range(1)), int'($urandom_range(3) != 0),
                 int'($urandom_range(19) != 0), "rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
